// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter sharing one APB completer among MST requesters; optional ACCESS timeout via APB_ARB_TIMEOUT_EN.
// Latency: request seen in cycle 0, SETUP 1, ACCESS 2.., mst_pready pulse one cycle after slv_pready.
// Backpressure: losers hold their request with mst_pready low; one transfer in flight, slv_pready stalls ACCESS.
module apb_mst_arbiter #(
    parameter int MST     = 2,
    parameter int PADDR   = 32,
    parameter int PDATA   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [MST-1:0]          mst_psel,
    input  logic [MST-1:0]          mst_penable,
    input  logic [MST*3-1:0]        mst_pprot,
    input  logic [MST*PADDR-1:0]    mst_paddr,
    input  logic [MST-1:0]          mst_pwrite,
    input  logic [MST*PDATA/8-1:0]  mst_pstrb,
    input  logic [MST*PDATA-1:0]    mst_pwdata,
    output logic [MST*PDATA-1:0]    mst_prdata,
    output logic [MST-1:0]          mst_pslverr,
    output logic [MST-1:0]          mst_pready,
    output logic                    slv_psel,
    output logic                    slv_penable,
    output logic [2:0]              slv_pprot,
    output logic [PADDR-1:0]        slv_paddr,
    output logic                    slv_pwrite,
    output logic [PDATA/8-1:0]      slv_pstrb,
    output logic [PDATA-1:0]        slv_pwdata,
    input  logic [PDATA-1:0]        slv_prdata,
    input  logic                    slv_pslverr,
    input  logic                    slv_pready
);

    localparam int SW = PDATA / 8;
    localparam int PW = (MST > 1) ? $clog2(MST) : 1;

    if (MST < 1 || MST > 16 || PDATA % 8 != 0 || PADDR < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_mst_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ptr, gnt;
    logic [PW-1:0]  arb_idx;
    logic           arb_vld;
    logic [MST-1:0] hi_req;
    logic           to_hit;

    logic                   slv_psel_d, slv_penable_d, slv_pwrite_d;
    logic [2:0]             slv_pprot_d;
    logic [PADDR-1:0]       slv_paddr_d;
    logic [SW-1:0]          slv_pstrb_d;
    logic [PDATA-1:0]       slv_pwdata_d;
    logic [MST-1:0]         mst_pready_d, mst_pslverr_d;
    logic [MST*PDATA-1:0]   mst_prdata_d;

    // penable carries no information for a registered replay of the request
    logic unused_penable;
    assign unused_penable = ^mst_penable;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_req  = '0;
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < MST; i++) begin
            hi_req[i] = mst_psel[i] && (i >= int'(ptr));
        end
        for (int i = MST - 1; i >= 0; i--) begin
            if (mst_psel[i]) begin
                arb_vld = 1'b1;
                arb_idx = PW'(i);
            end
        end
        for (int i = MST - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                arb_idx = PW'(i);
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

    logic [TW-1:0] to_cnt;

    // A ready arriving in the expiry cycle takes precedence over the timeout.
    assign to_hit = (state == ACCESS) && !slv_pready && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !slv_pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (slv_pready || to_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output.
    always_comb begin
        slv_psel_d    = (state_nxt == SETUP) || (state_nxt == ACCESS);
        slv_penable_d = (state_nxt == ACCESS);
        slv_pprot_d   = slv_pprot;
        slv_paddr_d   = slv_paddr;
        slv_pwrite_d  = slv_pwrite;
        slv_pstrb_d   = slv_pstrb;
        slv_pwdata_d  = slv_pwdata;
        mst_pready_d  = '0;
        mst_pslverr_d = '0;
        mst_prdata_d  = '0;
        if (state == IDLE && arb_vld) begin
            slv_pprot_d  = mst_pprot[int'(arb_idx)*3 +: 3];
            slv_paddr_d  = mst_paddr[int'(arb_idx)*PADDR +: PADDR];
            slv_pwrite_d = mst_pwrite[arb_idx];
            slv_pstrb_d  = mst_pstrb[int'(arb_idx)*SW +: SW];
            slv_pwdata_d = mst_pwdata[int'(arb_idx)*PDATA +: PDATA];
        end
        if (state == ACCESS && state_nxt == RESP) begin
            mst_pready_d[gnt]  = 1'b1;
            mst_pslverr_d[gnt] = slv_pready ? slv_pslverr : 1'b1;
            if (slv_pready && !slv_pwrite) begin
                mst_prdata_d[int'(gnt)*PDATA +: PDATA] = slv_prdata;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            slv_psel    <= 1'b0;
            slv_penable <= 1'b0;
            slv_pprot   <= '0;
            slv_paddr   <= '0;
            slv_pwrite  <= 1'b0;
            slv_pstrb   <= '0;
            slv_pwdata  <= '0;
            mst_pready  <= '0;
            mst_pslverr <= '0;
            mst_prdata  <= '0;
        end else begin
            state       <= state_nxt;
            slv_psel    <= slv_psel_d;
            slv_penable <= slv_penable_d;
            slv_pprot   <= slv_pprot_d;
            slv_paddr   <= slv_paddr_d;
            slv_pwrite  <= slv_pwrite_d;
            slv_pstrb   <= slv_pstrb_d;
            slv_pwdata  <= slv_pwdata_d;
            mst_pready  <= mst_pready_d;
            mst_pslverr <= mst_pslverr_d;
            mst_prdata  <= mst_prdata_d;
            if (state == IDLE && arb_vld) begin
                gnt <= arb_idx;
                ptr <= (arb_idx == PW'(MST - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

endmodule
